lc3_control_fsm: RTL and testbench
==================================

// Module: lc3_control_fsm
// PURPOSE
// - Moore control FSM for the LC-3 datapath: sequences fetch, decode and execute.
// - Drives all register loads (incl. LD_CC/LD_BEN to the NZP block), bus gates, mux selects, SRAM strobes.
// - Consumes BEN from the NZP block during DECODE to resolve BR.
// - Subset: ADD, AND, NOT, BR, JMP, JSR, LDR, STR, PAUSE(1101); other opcodes -> no-op, back to fetch.
// PARAMETERS
// - MEM_WAIT  default 2  cycles each SRAM read/write state is held (>=1)
// PORTS
// - Clk       in   1  clock, rising edge
// - Reset     in   1  asynchronous, active-high; FSM -> HALTED
// - Run       in   1  start pulse; sampled only in HALTED
// - Continue  in   1  resume handshake for PAUSE
// - Opcode    in   4  IR[15:12]
// - IR_5      in   1  ADD/AND immediate select
// - IR_11     in   1  JSR (1) vs JSRR (0)
// - BEN       in   1  branch enable from NZP, valid in DECODE
// - LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC  out 1 each  register loads
// - GatePC, GateMDR, GateALU, GateMARMUX  out 1 each  bus drivers (at most one high)
// - PCMUX     out  2  00 PC+1, 01 bus, 10 address adder
// - DRMUX     out  1  0 IR[11:9], 1 R7
// - SR1MUX    out  1  0 IR[11:9], 1 IR[8:6]
// - SR2MUX    out  1  equals IR_5 in ADD/AND execute, else 0
// - ADDR1MUX  out  1  0 PC, 1 SR1
// - ADDR2MUX  out  2  00 zero, 01 off6, 10 off9, 11 off11
// - ALUK      out  2  00 ADD, 01 AND, 10 NOT, 11 PASS A
// - Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  out 1 each  SRAM strobes, active-low
// BEHAVIOUR
// - Outputs combinational from state only. Default/reset: all LD_*/Gate* 0, all selects 0,
//   all Mem_* 1.
// - HALTED: Run=1 -> FETCH1.
// - FETCH1: MAR<-PC (GatePC, LD_MAR); PC<-PC+1 (LD_PC, PCMUX=00).
// - FETCH2: CE/UB/LB/OE=0, LD_MDR=1; held MEM_WAIT cycles via wait counter.
// - FETCH3: IR<-MDR (GateMDR, LD_IR).
// - DECODE: LD_BEN=1.
//   - BR: BEN=1 -> BR_EXEC; BEN=0 -> FETCH1.
//   - Others -> own execute state; PAUSE -> PAUSE_IR1; unsupported -> FETCH1.
// - ADD/AND/NOT_EXEC: GateALU, LD_REG, LD_CC, SR1MUX=1, ALUK per op, SR2MUX=IR_5 (ADD/AND) -> FETCH1.
// - BR_EXEC: LD_PC, PCMUX=10, ADDR1MUX=0, ADDR2MUX=10 -> FETCH1.
// - JMP_EXEC: LD_PC, PCMUX=10, ADDR1MUX=1, SR1MUX=1, ADDR2MUX=00 -> FETCH1.
// - JSR1: R7<-PC (GatePC, DRMUX=1, LD_REG).
//   JSR2: LD_PC, PCMUX=10; IR_11=1: ADDR1MUX=0, ADDR2MUX=11; else ADDR1MUX=1, SR1MUX=1, ADDR2MUX=00.
// - LDR1: MAR<-SR1+off6 (GateMARMUX, LD_MAR, SR1MUX=1, ADDR1MUX=1, ADDR2MUX=01).
//   LDR2: read as FETCH2. LDR3: GateMDR, LD_REG, LD_CC.
// - STR1: MAR as LDR1. STR2: MDR<-SR (SR1MUX=0, ALUK=11, GateALU, LD_MDR).
//   STR3: CE/UB/LB/WE=0 for MEM_WAIT cycles, OE=1.
// - PAUSE_IR1: stay while Continue=0; Continue=1 -> PAUSE_IR2.
//   PAUSE_IR2: stay while Continue=1; Continue=0 -> FETCH1.
// - Wait counter: clears on entry to each memory state; exit when count==MEM_WAIT-1. No wrap.
// - Reset asserted any state (incl. mid-memory): HALTED and idle outputs immediately;
//   counter cleared; no partial write completes.
// - Run outside HALTED ignored.
// STRUCTURE
// - lc3_ctrl_pkg: state_t enum, opcode localparams, PCMUX/ADDR2MUX/ALUK encodings.
// - Sub-module lc3_mem_wait_counter: start, done; shared by FETCH2/LDR2/STR3.
// TESTING
// - Reset mid-FETCH2 -> same cycle: Mem_OE=1, LD_*=0; next edges HALTED until Run=1.
// - Run pulse, MEM_WAIT=2, Opcode=0001 -> FETCH1 1 cyc, Mem_OE=0 exactly 2 cyc, LD_IR 1 cyc, DECODE,
//   then LD_REG=LD_CC=1 for 1 cyc, back to FETCH1 (7 cycles total).
// - Opcode=0000: BEN=1 -> LD_PC=1, PCMUX=10, ADDR2MUX=10 one cycle; BEN=0 -> FETCH1, no LD_PC.
// - Opcode=0111 (STR) -> GateALU+ALUK=11+LD_MDR, then Mem_WE=0 exactly MEM_WAIT cycles, Mem_OE=1.
// - Opcode=0100, IR_11=0 -> JSR1 DRMUX=1/LD_REG, then JSR2 ADDR1MUX=1/ADDR2MUX=00/LD_PC.
// - Opcode=1101 -> holds in PAUSE_IR1 10 cyc with Continue=0; Continue 1 then 0 -> FETCH1.

Source files
------------

// File: rtl/lc3_ctrl_pkg.sv
// Shared types and encodings for the LC-3 control FSM: state enum, opcodes, mux codes.
package lc3_ctrl_pkg;

  typedef enum logic [4:0] {
    S_HALTED, S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
    S_ADD_EXEC, S_AND_EXEC, S_NOT_EXEC, S_BR_EXEC, S_JMP_EXEC,
    S_JSR1, S_JSR2, S_LDR1, S_LDR2, S_LDR3,
    S_STR1, S_STR2, S_STR3, S_PAUSE_IR1, S_PAUSE_IR2
  } state_t;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  localparam logic [1:0] PCMUX_PC1  = 2'b00;
  localparam logic [1:0] PCMUX_BUS  = 2'b01;
  localparam logic [1:0] PCMUX_ADDR = 2'b10;

  localparam logic [1:0] ADDR2_ZERO  = 2'b00;
  localparam logic [1:0] ADDR2_OFF6  = 2'b01;
  localparam logic [1:0] ADDR2_OFF9  = 2'b10;
  localparam logic [1:0] ADDR2_OFF11 = 2'b11;

  localparam logic [1:0] ALUK_ADD  = 2'b00;
  localparam logic [1:0] ALUK_AND  = 2'b01;
  localparam logic [1:0] ALUK_NOT  = 2'b10;
  localparam logic [1:0] ALUK_PASS = 2'b11;

  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH2) || (s == S_LDR2) || (s == S_STR3);
  endfunction

endpackage

// File: rtl/lc3_control_fsm_if.sv
// Control bundle between the LC-3 control FSM (master) and the datapath/SRAM (slave).
// Handshakes: Run is a level sampled only while halted; Continue is a two-phase
// level handshake (raise to leave PAUSE_IR1, drop to leave PAUSE_IR2).
interface lc3_control_fsm_if;
  logic       Run, Continue, IR_5, IR_11, BEN;
  logic [3:0] Opcode;
  logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC;
  logic       GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
  logic       Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;

  modport master (
    input  Run, Continue, Opcode, IR_5, IR_11, BEN,
    output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC,
    output GatePC, GateMDR, GateALU, GateMARMUX,
    output PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
    output Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
  );

  modport slave (
    output Run, Continue, Opcode, IR_5, IR_11, BEN,
    input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC,
    input  GatePC, GateMDR, GateALU, GateMARMUX,
    input  PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
    input  Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
  );
endinterface

// File: rtl/lc3_mem_wait_counter.sv
// Counts cycles spent in an SRAM access state; done marks the last held cycle.
module lc3_mem_wait_counter #(
  parameter int MEM_WAIT = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic start,
  input  logic en,
  output logic done
);
  localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign done = (cnt_q == CW'(MEM_WAIT - 1));

  // Saturates at done so a stalled state never wraps back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (start)           cnt_d = '0;
    else if (en && !done) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/lc3_control_fsm.sv
// Moore control FSM sequencing LC-3 fetch/decode/execute for the supported subset.
module lc3_control_fsm
  import lc3_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic                Clk,
  input  logic                Reset,
  lc3_control_fsm_if.master   bus,
  output state_t              dbg_state
);
  state_t state_q, state_d;
  logic   wait_start, wait_en, wait_done;

  assign dbg_state  = state_q;
  assign wait_en    = is_mem_state(state_q);
  assign wait_start = is_mem_state(state_d) && (state_d != state_q);

  lc3_mem_wait_counter #(.MEM_WAIT(MEM_WAIT)) u_wait (
    .Clk   (Clk),
    .Reset (Reset),
    .start (wait_start),
    .en    (wait_en),
    .done  (wait_done)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= S_HALTED;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    bus.LD_MAR     = 1'b0;
    bus.LD_MDR     = 1'b0;
    bus.LD_IR      = 1'b0;
    bus.LD_BEN     = 1'b0;
    bus.LD_CC      = 1'b0;
    bus.LD_REG     = 1'b0;
    bus.LD_PC      = 1'b0;
    bus.GatePC     = 1'b0;
    bus.GateMDR    = 1'b0;
    bus.GateALU    = 1'b0;
    bus.GateMARMUX = 1'b0;
    bus.PCMUX      = PCMUX_PC1;
    bus.DRMUX      = 1'b0;
    bus.SR1MUX     = 1'b0;
    bus.SR2MUX     = 1'b0;
    bus.ADDR1MUX   = 1'b0;
    bus.ADDR2MUX   = ADDR2_ZERO;
    bus.ALUK       = ALUK_ADD;
    bus.Mem_CE     = 1'b1;
    bus.Mem_UB     = 1'b1;
    bus.Mem_LB     = 1'b1;
    bus.Mem_OE     = 1'b1;
    bus.Mem_WE     = 1'b1;

    case (state_q)
      S_HALTED: if (bus.Run) state_d = S_FETCH1;
      S_FETCH1: begin
        bus.GatePC = 1'b1; bus.LD_MAR = 1'b1; bus.LD_PC = 1'b1;
        state_d = S_FETCH2;
      end
      S_FETCH2, S_LDR2: begin
        bus.Mem_CE = 1'b0; bus.Mem_UB = 1'b0; bus.Mem_LB = 1'b0; bus.Mem_OE = 1'b0;
        bus.LD_MDR = 1'b1;
        if (wait_done) state_d = (state_q == S_FETCH2) ? S_FETCH3 : S_LDR3;
      end
      S_FETCH3: begin
        bus.GateMDR = 1'b1; bus.LD_IR = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        bus.LD_BEN = 1'b1;
        case (bus.Opcode)
          OP_BR:    state_d = bus.BEN ? S_BR_EXEC : S_FETCH1;
          OP_ADD:   state_d = S_ADD_EXEC;
          OP_AND:   state_d = S_AND_EXEC;
          OP_NOT:   state_d = S_NOT_EXEC;
          OP_JMP:   state_d = S_JMP_EXEC;
          OP_JSR:   state_d = S_JSR1;
          OP_LDR:   state_d = S_LDR1;
          OP_STR:   state_d = S_STR1;
          OP_PAUSE: state_d = S_PAUSE_IR1;
          default:  state_d = S_FETCH1;
        endcase
      end
      S_ADD_EXEC, S_AND_EXEC, S_NOT_EXEC: begin
        bus.GateALU = 1'b1; bus.LD_REG = 1'b1; bus.LD_CC = 1'b1; bus.SR1MUX = 1'b1;
        bus.ALUK   = (state_q == S_ADD_EXEC) ? ALUK_ADD :
                     (state_q == S_AND_EXEC) ? ALUK_AND : ALUK_NOT;
        bus.SR2MUX = (state_q != S_NOT_EXEC) && bus.IR_5;
        state_d = S_FETCH1;
      end
      S_BR_EXEC: begin
        bus.LD_PC = 1'b1; bus.PCMUX = PCMUX_ADDR; bus.ADDR2MUX = ADDR2_OFF9;
        state_d = S_FETCH1;
      end
      S_JMP_EXEC: begin
        bus.LD_PC = 1'b1; bus.PCMUX = PCMUX_ADDR; bus.ADDR1MUX = 1'b1; bus.SR1MUX = 1'b1;
        state_d = S_FETCH1;
      end
      S_JSR1: begin
        bus.GatePC = 1'b1; bus.DRMUX = 1'b1; bus.LD_REG = 1'b1;
        state_d = S_JSR2;
      end
      S_JSR2: begin
        bus.LD_PC = 1'b1; bus.PCMUX = PCMUX_ADDR;
        if (bus.IR_11) bus.ADDR2MUX = ADDR2_OFF11;
        else begin
          bus.ADDR1MUX = 1'b1; bus.SR1MUX = 1'b1;
        end
        state_d = S_FETCH1;
      end
      S_LDR1, S_STR1: begin
        bus.GateMARMUX = 1'b1; bus.LD_MAR = 1'b1; bus.SR1MUX = 1'b1;
        bus.ADDR1MUX = 1'b1; bus.ADDR2MUX = ADDR2_OFF6;
        state_d = (state_q == S_LDR1) ? S_LDR2 : S_STR2;
      end
      S_LDR3: begin
        bus.GateMDR = 1'b1; bus.LD_REG = 1'b1; bus.LD_CC = 1'b1;
        state_d = S_FETCH1;
      end
      S_STR2: begin
        bus.ALUK = ALUK_PASS; bus.GateALU = 1'b1; bus.LD_MDR = 1'b1;
        state_d = S_STR3;
      end
      S_STR3: begin
        bus.Mem_CE = 1'b0; bus.Mem_UB = 1'b0; bus.Mem_LB = 1'b0; bus.Mem_WE = 1'b0;
        if (wait_done) state_d = S_FETCH1;
      end
      S_PAUSE_IR1: if (bus.Continue)  state_d = S_PAUSE_IR2;
      S_PAUSE_IR2: if (!bus.Continue) state_d = S_FETCH1;
      default: state_d = S_HALTED;
    endcase
  end
endmodule

// File: tb/tb_lc3_control_fsm.sv
// Randomized bench for lc3_control_fsm: per-cycle expected output words from an instruction-level model.
module tb_lc3_control_fsm;
  import lc3_ctrl_pkg::*;

  localparam int MW = 2;

  typedef struct packed {
    logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc;
    logic gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux;
    logic drmux, sr1mux, sr2mux, addr1mux;
    logic [1:0] addr2mux, aluk;
    logic ce, ub, lb, oe, we;
  } out_t;

  localparam int W = $bits(out_t);

  logic   Clk = 1'b0;
  logic   Reset;
  state_t dbg_state;
  int     n_checks = 0;
  int     n_errors = 0;

  logic [W-1:0] exp_q[$];
  logic         cont_q[$];

  lc3_control_fsm_if bus ();

  lc3_control_fsm #(.MEM_WAIT(MW)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic out_t sample();
    out_t o;
    o = '{bus.LD_MAR, bus.LD_MDR, bus.LD_IR, bus.LD_BEN, bus.LD_CC, bus.LD_REG, bus.LD_PC,
          bus.GatePC, bus.GateMDR, bus.GateALU, bus.GateMARMUX, bus.PCMUX, bus.DRMUX,
          bus.SR1MUX, bus.SR2MUX, bus.ADDR1MUX, bus.ADDR2MUX, bus.ALUK,
          bus.Mem_CE, bus.Mem_UB, bus.Mem_LB, bus.Mem_OE, bus.Mem_WE};
    return o;
  endfunction

  function automatic out_t idle();
    out_t o;
    o = '0;
    o.ce = 1'b1; o.ub = 1'b1; o.lb = 1'b1; o.oe = 1'b1; o.we = 1'b1;
    return o;
  endfunction

  function automatic out_t sram_read();
    out_t o;
    o = idle();
    o.ce = 1'b0; o.ub = 1'b0; o.lb = 1'b0; o.oe = 1'b0; o.ld_mdr = 1'b1;
    return o;
  endfunction

  task automatic push(input out_t o);
    exp_q.push_back(o);
    cont_q.push_back(1'($urandom_range(0, 1)));
  endtask

  // Instruction-level model: the cycle-by-cycle control word an instruction should produce.
  task automatic build_instr(input logic [3:0] op, input logic ir5, input logic ir11,
                             input logic ben, input int k, input int m);
    out_t o;
    o = idle(); o.ld_mar = 1; o.gate_pc = 1; o.ld_pc = 1; push(o);
    for (int i = 0; i < MW; i++) push(sram_read());
    o = idle(); o.gate_mdr = 1; o.ld_ir = 1; push(o);
    o = idle(); o.ld_ben = 1; push(o);
    case (op)
      4'd1, 4'd5, 4'd9: begin
        o = idle(); o.gate_alu = 1; o.ld_reg = 1; o.ld_cc = 1; o.sr1mux = 1;
        o.aluk   = (op == 4'd1) ? 2'd0 : (op == 4'd5) ? 2'd1 : 2'd2;
        o.sr2mux = (op == 4'd9) ? 1'b0 : ir5;
        push(o);
      end
      4'd0: if (ben) begin
        o = idle(); o.ld_pc = 1; o.pcmux = 2'd2; o.addr2mux = 2'd2; push(o);
      end
      4'd12: begin
        o = idle(); o.ld_pc = 1; o.pcmux = 2'd2; o.addr1mux = 1; o.sr1mux = 1; push(o);
      end
      4'd4: begin
        o = idle(); o.gate_pc = 1; o.drmux = 1; o.ld_reg = 1; push(o);
        o = idle(); o.ld_pc = 1; o.pcmux = 2'd2;
        if (ir11) o.addr2mux = 2'd3;
        else begin o.addr1mux = 1; o.sr1mux = 1; end
        push(o);
      end
      4'd6, 4'd7: begin
        o = idle(); o.gate_marmux = 1; o.ld_mar = 1; o.sr1mux = 1; o.addr1mux = 1;
        o.addr2mux = 2'd1; push(o);
        if (op == 4'd6) begin
          for (int i = 0; i < MW; i++) push(sram_read());
          o = idle(); o.gate_mdr = 1; o.ld_reg = 1; o.ld_cc = 1; push(o);
        end else begin
          o = idle(); o.aluk = 2'd3; o.gate_alu = 1; o.ld_mdr = 1; push(o);
          o = idle(); o.ce = 0; o.ub = 0; o.lb = 0; o.we = 0;
          for (int i = 0; i < MW; i++) push(o);
        end
      end
      4'd13: begin
        // Pause lasts k idle cycles, then Continue high for m cycles, then low once.
        for (int i = 0; i < k; i++) begin exp_q.push_back(idle()); cont_q.push_back(1'b0); end
        for (int i = 0; i < m; i++) begin exp_q.push_back(idle()); cont_q.push_back(1'b1); end
        exp_q.push_back(idle()); cont_q.push_back(1'b0);
      end
      default: ;
    endcase
  endtask

  task automatic step(input string tag);
    out_t e;
    e = out_t'(exp_q.pop_front());
    bus.Continue = cont_q.pop_front();
    bus.Run = 1'($urandom_range(0, 1));
    @(negedge Clk);
    check_eq(tag, 32'(sample()), 32'(e));
    @(posedge Clk); #1;
  endtask

  task automatic run_instr(input logic [3:0] op, input logic ir5, input logic ir11,
                           input logic ben, input int k, input int m);
    int c;
    bus.Opcode = op; bus.IR_5 = ir5; bus.IR_11 = ir11; bus.BEN = ben;
    build_instr(op, ir5, ir11, ben, k, m);
    c = 0;
    while (exp_q.size() > 0) begin
      step($sformatf("op%0d_cyc%0d", op, c));
      c++;
    end
  endtask

  task automatic run_pulse();
    bus.Run = 1'b1;
    @(negedge Clk);
    check_eq("halted_run", 32'(sample()), 32'(idle()));
    @(posedge Clk); #1;
    bus.Run = 1'b0;
  endtask

  // Runs n cycles of an instruction, then resets inside the following cycle.
  task automatic reset_mid(input logic [3:0] op, input int n, input string tag);
    bus.Opcode = op; bus.IR_5 = 1'b0; bus.IR_11 = 1'b0; bus.BEN = 1'b0;
    build_instr(op, 1'b0, 1'b0, 1'b0, 0, 1);
    for (int i = 0; i < n; i++) step($sformatf("%s_pre%0d", tag, i));
    #1;
    check_eq({tag, "_before"}, 32'(sample()), 32'(exp_q[0]));
    exp_q.delete(); cont_q.delete();
    Reset = 1'b1; bus.Run = 1'b0;
    #1;
    check_eq({tag, "_async"}, 32'(sample()), 32'(idle()));
    @(posedge Clk); #1;
    Reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      check_eq({tag, "_halt_out"}, 32'(sample()), 32'(idle()));
      check_eq({tag, "_halt_st"}, 32'(dbg_state), 32'(S_HALTED));
      @(posedge Clk); #1;
    end
    run_pulse();
  endtask

  initial begin
    Reset = 1'b1;
    bus.Run = 1'b0; bus.Continue = 1'b0; bus.Opcode = 4'h0;
    bus.IR_5 = 1'b0; bus.IR_11 = 1'b0; bus.BEN = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check_eq("reset_out", 32'(sample()), 32'(idle()));
    check_eq("reset_state", 32'(dbg_state), 32'(S_HALTED));
    @(posedge Clk); #1;
    Reset = 1'b0;

    for (int i = 0; i < 3; i++) begin
      bus.Continue = 1'($urandom_range(0, 1));
      bus.Opcode = 4'($urandom_range(0, 15));
      @(negedge Clk);
      check_eq("halted_idle", 32'(sample()), 32'(idle()));
      @(posedge Clk); #1;
    end
    run_pulse();

    run_instr(4'b0001, 1'b1, 1'b0, 1'b0, 0, 1);
    run_instr(4'b0000, 1'b0, 1'b0, 1'b1, 0, 1);
    run_instr(4'b0000, 1'b0, 1'b0, 1'b0, 0, 1);
    run_instr(4'b0111, 1'b0, 1'b0, 1'b0, 0, 1);
    run_instr(4'b0100, 1'b0, 1'b0, 1'b0, 0, 1);
    run_instr(4'b1101, 1'b0, 1'b0, 1'b0, 10, 2);

    for (int i = 0; i < 60; i++)
      run_instr(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(0, 5), $urandom_range(1, 3));

    reset_mid(4'b0001, 1, "rst_fetch2");
    reset_mid(4'b0111, 2 + MW + 3, "rst_str3");
    run_instr(4'b0110, 1'b0, 1'b0, 1'b0, 0, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
